pipe_ctrl_stage: RTL and testbench

Registered, parametrised successor to the pipeline controller. It decodes one instruction per accepted handshake into the execute-stage control bundle and holds Z/C flags internally, with forwarding from execute. It resolves branches, jumps, calls and returns, and tracks call depth. It sits between fetch and execute, with valid/ready on both sides, a one-slot wrong-path flush, and a sticky halt state that replaces the simulation stop.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/ctrl_decode.sv | 87 ++++++++
 rtl/pipe_ctrl_stage.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control stage.
//   - opcode prefix / sub-op encodings
//   - pc_src encodings (PC_SEQ/PC_JMP/PC_RET/PC_BR)
//   - controller state enum (RUN/FLUSH/HALT)
//   - control-bundle struct handed to execute
package ctrl_pkg;

    // Opcode prefixes, matched against the top bits of the 6-bit opcode field
    localparam logic [1:0] OP2_ALU_R  = 2'b00;
    localparam logic [1:0] OP2_ALU_I  = 2'b01;
    localparam logic [2:0] OP3_MEM    = 3'b100;
    localparam logic [2:0] OP3_BRANCH = 3'b101;
    localparam logic [2:0] OP3_SHIFT  = 3'b110;
    localparam logic [3:0] OP4_JUMP   = 4'b1110;
    localparam logic [5:0] OP6_RET    = 6'b111100;

    // Sub-op field (instruction[IW-4:IW-5])
    localparam logic [1:0] SUB_LOAD  = 2'b00;
    localparam logic [1:0] SUB_STORE = 2'b01;
    localparam logic [1:0] BR_Z      = 2'b00;
    localparam logic [1:0] BR_NZ     = 2'b01;
    localparam logic [1:0] BR_C      = 2'b10;
    localparam logic [1:0] BR_NC     = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_RET = 2'b10;
    localparam logic [1:0] PC_BR  = 2'b11;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    typedef struct packed {
        logic       reg2_read_source;
        logic       mem_read_write;
        logic       mem_or_alu;
        logic       is_shift;
        logic       alu_src;
        logic       update_z_c;
        logic       reg_write_signal;
        logic       stack_push;
        logic       stack_pop;
        logic [1:0] pc_src;
        logic [1:0] scode;
        logic [2:0] acode;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder.
//   instruction  - fetched word, opcode in [IW-1:IW-6]
//   z, c         - effective flags (already forwarded by the caller)
//   ctrl         - control bundle for execute
//   is_redirect  - word changes the PC (taken branch, jmp, jsb, ret)
//   is_halt      - all-ones halt word
//   is_illegal   - unrecognised encoding; no bundle may issue
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IW = 19
) (
    input  logic [IW-1:0] instruction,
    input  logic          z,
    input  logic          c,
    output ctrl_t         ctrl,
    output logic          is_redirect,
    output logic          is_halt,
    output logic          is_illegal
);

    logic [5:0] op;
    logic [1:0] sub;
    logic       taken;

    assign op  = instruction[IW-1:IW-6];
    assign sub = instruction[IW-4:IW-5];

    always_comb begin
        case (sub)
            BR_Z:    taken = z;
            BR_NZ:   taken = !z;
            BR_C:    taken = c;
            default: taken = !c;
        endcase
    end

    always_comb begin
        ctrl        = '0;
        is_redirect = 1'b0;
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        // Halt is checked on the whole word first: its opcode would
        // otherwise fall into the 1111xx illegal space.
        if (&instruction) begin
            is_halt = 1'b1;
        end else if (op[5:4] == OP2_ALU_R || op[5:4] == OP2_ALU_I) begin
            ctrl.acode            = instruction[IW-3:IW-5];
            ctrl.alu_src          = (op[5:4] == OP2_ALU_I);
            ctrl.update_z_c       = 1'b1;
            ctrl.mem_or_alu       = 1'b1;
            ctrl.reg_write_signal = 1'b1;
        end else if (op[5:3] == OP3_SHIFT) begin
            ctrl.scode            = sub;
            ctrl.is_shift         = 1'b1;
            ctrl.mem_or_alu       = 1'b1;
            ctrl.reg_write_signal = 1'b1;
            ctrl.update_z_c       = 1'b1;
        end else if (op[5:3] == OP3_MEM) begin
            if (sub == SUB_LOAD) begin
                ctrl.reg2_read_source = 1'b1;
                ctrl.alu_src          = 1'b1;
                ctrl.reg_write_signal = 1'b1;
            end else if (sub == SUB_STORE) begin
                ctrl.reg2_read_source = 1'b1;
                ctrl.alu_src          = 1'b1;
                ctrl.mem_read_write   = 1'b1;
            end else begin
                is_illegal = 1'b1;
            end
        end else if (op[5:3] == OP3_BRANCH) begin
            ctrl.pc_src = taken ? PC_BR : PC_SEQ;
            is_redirect = taken;
        end else if (op[5:2] == OP4_JUMP) begin
            ctrl.pc_src     = PC_JMP;
            ctrl.stack_push = instruction[IW-5];  // jsb
            is_redirect     = 1'b1;
        end else if (op == OP6_RET) begin
            ctrl.pc_src    = PC_RET;
            ctrl.stack_pop = 1'b1;
            is_redirect    = 1'b1;
        end else begin
            is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: registered decode/control stage between fetch and execute.
//   clk, rst              - clock, async active-high reset
//   instruction/if_valid  - fetch side, id_ready back
//   id_valid/ex_ready     - execute side handshake for the control bundle
//   ex_flag_wr/zero/carry - execute flag write, forwarded into branch resolve
//   bundle outputs        - reg2_read_source .. acode
//   flush                 - one-cycle pulse with a redirecting bundle
//   halted                - sticky until rst
//   illegal/stack_ovf/stack_unf - one-cycle error pulses
//   call_depth            - tracked call depth
// Optional feature: define CTRL_STACK_CHECK_EN to track call depth and
// guard push/pop against overflow/underflow.
module pipe_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int IW          = 19,
    parameter int STACK_DEPTH = 8,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instruction,
    input  logic          if_valid,
    output logic          id_ready,
    input  logic          ex_ready,
    input  logic          ex_flag_wr,
    input  logic          ex_zero,
    input  logic          ex_carry,
    output logic          id_valid,
    output logic          reg2_read_source,
    output logic          mem_read_write,
    output logic          mem_or_alu,
    output logic          is_shift,
    output logic          alu_src,
    output logic          update_z_c,
    output logic          reg_write_signal,
    output logic          stack_push,
    output logic          stack_pop,
    output logic [1:0]    pc_src,
    output logic [1:0]    scode,
    output logic [2:0]    acode,
    output logic          flush,
    output logic          halted,
    output logic          illegal,
    output logic          stack_ovf,
    output logic          stack_unf,
    output logic [DW-1:0] call_depth
);

    state_t        state;
    ctrl_t         bundle_q;
    ctrl_t         ctrl_d, ctrl_i;
    logic          redir_d, redir_i, halt_d, ill_d;
    logic          ovf_i, unf_i;
    logic          zr, cr;
    logic [DW-1:0] depth_q, depth_n;
    logic          accept;

    assign id_ready = (ex_ready | !id_valid) & !halted;
    assign accept   = if_valid & id_ready;

    ctrl_decode #(.IW(IW)) u_dec (
        .instruction (instruction),
        .z           (ex_flag_wr ? ex_zero  : zr),
        .c           (ex_flag_wr ? ex_carry : cr),
        .ctrl        (ctrl_d),
        .is_redirect (redir_d),
        .is_halt     (halt_d),
        .is_illegal  (ill_d)
    );

    // Stack guard: a full-depth jsb still jumps but does not push; a ret
    // at depth 0 degrades to a sequential no-op.
    always_comb begin
        ctrl_i  = ctrl_d;
        redir_i = redir_d;
        ovf_i   = 1'b0;
        unf_i   = 1'b0;
        depth_n = depth_q;
`ifdef CTRL_STACK_CHECK_EN
        if (ctrl_d.stack_push) begin
            if (depth_q == DW'(STACK_DEPTH)) begin
                ctrl_i.stack_push = 1'b0;
                ovf_i             = 1'b1;
            end else begin
                depth_n = depth_q + 1'b1;
            end
        end
        if (ctrl_d.stack_pop) begin
            if (depth_q == '0) begin
                ctrl_i.stack_pop = 1'b0;
                ctrl_i.pc_src    = PC_SEQ;
                redir_i          = 1'b0;
                unf_i            = 1'b1;
            end else begin
                depth_n = depth_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            bundle_q  <= '0;
            id_valid  <= 1'b0;
            flush     <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            depth_q   <= '0;
            zr        <= 1'b0;
            cr        <= 1'b0;
        end else begin
            flush     <= 1'b0;
            illegal   <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            if (ex_flag_wr) begin
                zr <= ex_zero;
                cr <= ex_carry;
            end
            if (accept) begin
                // Default for every non-issuing accept: no bundle, clean outputs
                id_valid <= 1'b0;
                bundle_q <= '0;
                if (state == FLUSH) begin
                    state <= RUN;               // wrong-path word dropped
                end else if (ill_d) begin
                    illegal <= 1'b1;
                end else if (halt_d) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    bundle_q  <= ctrl_i;
                    id_valid  <= 1'b1;
                    flush     <= redir_i;
                    stack_ovf <= ovf_i;
                    stack_unf <= unf_i;
                    depth_q   <= depth_n;
                    state     <= redir_i ? FLUSH : RUN;
                end
            end else if (ex_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

    assign reg2_read_source = bundle_q.reg2_read_source;
    assign mem_read_write   = bundle_q.mem_read_write;
    assign mem_or_alu       = bundle_q.mem_or_alu;
    assign is_shift         = bundle_q.is_shift;
    assign alu_src          = bundle_q.alu_src;
    assign update_z_c       = bundle_q.update_z_c;
    assign reg_write_signal = bundle_q.reg_write_signal;
    assign stack_push       = bundle_q.stack_push;
    assign stack_pop        = bundle_q.stack_pop;
    assign pc_src           = bundle_q.pc_src;
    assign scode            = bundle_q.scode;
    assign acode            = bundle_q.acode;
    assign call_depth       = depth_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// tb_pipe_ctrl_stage: directed stimulus with a scoreboard queue; a monitor
// compares every consumed bundle (and every illegal pulse) against the
// expected entry pushed when the word was accepted.
module tb_pipe_ctrl_stage;

    localparam int IW = 19;
    localparam int SD = 2;
    localparam int DW = 2;
`ifdef CTRL_STACK_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    localparam logic [8:0] F_RRS = 9'h100, F_MRW = 9'h080, F_MOA = 9'h040,
                           F_SH  = 9'h020, F_AS  = 9'h010, F_UZC = 9'h008,
                           F_RW  = 9'h004, F_PSH = 9'h002, F_POP = 9'h001;

    typedef struct packed {
        logic          ill;
        logic [8:0]    f;
        logic [1:0]    pc;
        logic [1:0]    sc;
        logic [2:0]    ac;
        logic          fl;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] dep;
    } exp_t;

    typedef struct {
        exp_t  e;
        string n;
    } sb_t;

    logic          clk, rst;
    logic [IW-1:0] instruction;
    logic          if_valid, id_ready, ex_ready, ex_flag_wr, ex_zero, ex_carry;
    logic          id_valid, reg2_read_source, mem_read_write, mem_or_alu, is_shift;
    logic          alu_src, update_z_c, reg_write_signal, stack_push, stack_pop;
    logic [1:0]    pc_src, scode;
    logic [2:0]    acode;
    logic          flush, halted, illegal, stack_ovf, stack_unf;
    logic [DW-1:0] call_depth;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    pipe_ctrl_stage #(.IW(IW), .STACK_DEPTH(SD), .DW(DW)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .if_valid(if_valid),
        .id_ready(id_ready), .ex_ready(ex_ready), .ex_flag_wr(ex_flag_wr),
        .ex_zero(ex_zero), .ex_carry(ex_carry), .id_valid(id_valid),
        .reg2_read_source(reg2_read_source), .mem_read_write(mem_read_write),
        .mem_or_alu(mem_or_alu), .is_shift(is_shift), .alu_src(alu_src),
        .update_z_c(update_z_c), .reg_write_signal(reg_write_signal),
        .stack_push(stack_push), .stack_pop(stack_pop), .pc_src(pc_src),
        .scode(scode), .acode(acode), .flush(flush), .halted(halted),
        .illegal(illegal), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .call_depth(call_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [8:0] f, input logic [1:0] pc = 2'b00,
                                input logic [1:0] sc = 2'b00, input logic [2:0] ac = 3'b000,
                                input logic fl = 1'b0, input logic ill = 1'b0,
                                input logic ovf = 1'b0, input logic unf = 1'b0,
                                input logic [DW-1:0] dep = '0);
        exp_t e;
        e = '{ill: ill, f: f, pc: pc, sc: sc, ac: ac, fl: fl, ovf: ovf, unf: unf, dep: dep};
        return e;
    endfunction

    function automatic logic [IW-1:0] w(input logic [5:0] op);
        return {op, 13'h0000};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // Present a word (call at posedge+1); expected entry queued on accept.
    task automatic send(input logic [IW-1:0] word, input bit push, input exp_t e, input string n);
        int t;
        t = 0;
        instruction = word;
        if_valid    = 1'b1;
        @(negedge clk);
        while (!id_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!id_ready) begin
            errors++;
            $display("FAIL accept_timeout %s", n);
        end
        @(posedge clk);
        if (push) sb.push_back('{e, n});
        #1 if_valid = 1'b0;
    endtask

    // Wrong-path word following a redirect: must not produce a bundle.
    task automatic drop(input string n);
        send(w(6'b000100), 1'b0, mk(9'h0), n);
        @(negedge clk);
        chk(n, {31'd0, id_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per bundle consumed by execute or per illegal pulse
    always @(negedge clk) begin
        exp_t act;
        sb_t  s;
        if (!rst && ((id_valid && ex_ready) || illegal)) begin
            act = '{ill: illegal,
                    f: {reg2_read_source, mem_read_write, mem_or_alu, is_shift, alu_src,
                        update_z_c, reg_write_signal, stack_push, stack_pop},
                    pc: pc_src, sc: scode, ac: acode, fl: flush,
                    ovf: stack_ovf, unf: stack_unf, dep: call_depth};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %h want none", act);
            end else begin
                s = sb.pop_front();
                if (act !== s.e) begin
                    errors++;
                    $display("FAIL %s got %h want %h", s.n, act, s.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    localparam logic [8:0] ALU = F_MOA | F_UZC | F_RW;

    initial begin
        rst = 1'b1; if_valid = 1'b0; ex_ready = 1'b1; instruction = '0;
        ex_flag_wr = 1'b0; ex_zero = 1'b0; ex_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {26'd0, id_valid, flush, halted, illegal, stack_ovf, stack_unf}, 32'd0);
        chk("reset_bundle", {reg2_read_source, mem_read_write, mem_or_alu, is_shift, alu_src,
                             update_z_c, reg_write_signal, stack_push, stack_pop, pc_src, scode,
                             acode, call_depth}, 32'd0);
        chk("reset_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic decode classes, back to back
        send(w(6'b000100), 1'b1, mk(ALU, 2'b00, 2'b00, 3'b010), "rtype");
        send(w(6'b011010), 1'b1, mk(ALU | F_AS, 2'b00, 2'b00, 3'b101), "imm");
        send(w(6'b110100), 1'b1, mk(F_SH | F_MOA | F_RW | F_UZC, 2'b00, 2'b10), "shift");
        send(w(6'b100010), 1'b1, mk(F_RRS | F_AS | F_MRW), "store");

        // Stall: load held while execute is not ready, store waits
        send(w(6'b100000), 1'b1, mk(F_RRS | F_AS | F_RW), "load_stall");
        ex_ready    = 1'b0;
        instruction = w(6'b100010);
        if_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_ready", {31'd0, id_ready}, 32'd0);
            chk("stall_hold", {29'd0, reg2_read_source, alu_src, reg_write_signal}, 32'd7);
        end
        @(posedge clk);
        #1 ex_ready = 1'b1;
        send(w(6'b100010), 1'b1, mk(F_RRS | F_AS | F_MRW), "store_after_stall");

        // Branches: forwarded flags win over Zr/Cr
        ex_flag_wr = 1'b1; ex_zero = 1'b1; ex_carry = 1'b0;
        send(w(6'b101000), 1'b1, mk(9'h0, 2'b11, 2'b00, 3'b000, 1'b1), "br_z_fwd");
        ex_flag_wr = 1'b0;
        drop("drop_br_z");
        send(w(6'b101010), 1'b1, mk(9'h0), "br_nz_not_taken");
        send(w(6'b000100), 1'b1, mk(ALU, 2'b00, 2'b00, 3'b010), "after_not_taken");
        ex_flag_wr = 1'b1; ex_zero = 1'b0; ex_carry = 1'b1;
        send(w(6'b101100), 1'b1, mk(9'h0, 2'b11, 2'b00, 3'b000, 1'b1), "br_c_fwd");
        ex_flag_wr = 1'b0;
        drop("drop_br_c");
        send(w(6'b101110), 1'b1, mk(9'h0), "br_nc_reg");
        send(w(6'b101000), 1'b1, mk(9'h0), "br_z_reg");

        // Jumps, calls, returns
        send(w(6'b111000), 1'b1, mk(9'h0, 2'b01, 2'b00, 3'b000, 1'b1), "jmp");
        drop("drop_jmp");
        for (int i = 0; i < 3; i++) begin
            send(w(6'b111010), 1'b1,
                 mk((SC && i == 2) ? 9'h0 : F_PSH, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0,
                    SC && i == 2, 1'b0, SC ? ((i == 0) ? 2'd1 : 2'd2) : 2'd0), "jsb");
            drop("drop_jsb");
        end
        for (int i = 0; i < 3; i++) begin
            if (SC && i == 2) begin
                send(w(6'b111100), 1'b1, mk(9'h0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1),
                     "ret_underflow");
                send(w(6'b000100), 1'b1, mk(ALU, 2'b00, 2'b00, 3'b010), "after_unf");
            end else begin
                send(w(6'b111100), 1'b1,
                     mk(F_POP, 2'b10, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
                        SC ? ((i == 0) ? 2'd1 : 2'd0) : 2'd0), "ret");
                drop("drop_ret");
            end
        end

        // Illegal encoding: one-cycle pulse, no bundle
        send(w(6'b100110), 1'b1, mk(9'h0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1), "illegal");
        repeat (2) @(negedge clk);
        chk("illegal_pulse", {30'd0, illegal, id_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset during a stall drops the bundle and clears Zr
        ex_flag_wr = 1'b1; ex_zero = 1'b1;
        send(w(6'b100000), 1'b1, mk(F_RRS | F_AS | F_RW), "load_lost");
        ex_flag_wr = 1'b0; ex_zero = 1'b0;
        ex_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_stall_outs", {26'd0, id_valid, flush, halted, illegal, stack_ovf, stack_unf}, 32'd0);
        chk("rst_stall_bundle", {reg2_read_source, alu_src, reg_write_signal, pc_src,
                                 call_depth}, 32'd0);
        sb.delete();
        ex_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(w(6'b101000), 1'b1, mk(9'h0), "br_z_after_rst");

        // Halt: sticky, blocks fetch, cleared only by reset
        send({IW{1'b1}}, 1'b0, mk(9'h0), "halt");
        instruction = w(6'b000100);
        if_valid    = 1'b1;
        @(negedge clk);
        chk("halted", {30'd0, halted, id_valid}, 32'd2);
        repeat (10) begin
            @(negedge clk);
            chk("halt_ready", {31'd0, id_ready}, 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        if_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send(w(6'b011010), 1'b1, mk(ALU | F_AS, 2'b00, 2'b00, 3'b101), "imm_after_halt");
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
